apb_rr_master: RTL and testbench
================================

# apb_rr_master

Round-robin APB bus master that shares one `APB_int` bus between `NUM_REQ` local requesters. Each requester posts a single read or write command. The block arbitrates, then runs the APB SETUP/ACCESS sequence on the shared bus. It returns read data, or a timeout error, to the winning requester. It sits on the master side of `APB_int`, in front of one or more slaves.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width; matches `APB_int.addr`.
- `DATA_W`, 8: data width; matches `APB_int.r_data` / `w_data`.
- `TIMEOUT`, 16: maximum ACCESS cycles with `ready`=0 before abort. 0 disables the timeout.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester command pending.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_grant`  out  NUM_REQ  one-hot, one-cycle pulse: command accepted.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse: command finished.
- `rsp_rdata`  out  DATA_W  read data; valid with `rsp_valid`. 0 for writes and errors.
- `rsp_err`  out  1  timeout abort; valid with `rsp_valid`.
- `addr`, `w_data`  out  ADDR_W, DATA_W  APB address and write data.
- `r_data`  in  DATA_W  APB read data.
- `selx`, `enable`, `write`, `read`  out  1 each  APB control.
- `ready`  in  1  slave ready. Tie to 1 for zero-wait slaves.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - If any `req_valid` is set, pick the winner by round-robin: the search starts at `last+1` and wraps modulo NUM_REQ.
  - At the clock edge, latch the winner's addr, wdata and write bit, update `last` to the winner, pulse `req_grant[winner]`, and go to SETUP.
  - With no request, stay in IDLE.
- **SETUP** (exactly one cycle)
  - `selx`=1, `enable`=0.
  - `addr`, `w_data`, `write` and `read` = ~write are driven from the latched values.
  - Go to ACCESS; clear the wait counter.
- **ACCESS**
  - `selx`=1, `enable`=1; address, data and control held stable.
  - `ready`=1: capture `r_data` if the command is a read (else 0) into `rsp_rdata`, set `rsp_err`=0, pulse `rsp_valid[winner]`, and go to IDLE.
  - `ready`=0: increment the wait counter.
  - If the counter reaches TIMEOUT and TIMEOUT≠0: abort, set `rsp_err`=1 and `rsp_rdata`=0, pulse `rsp_valid[winner]`, and go to IDLE.
- Outside SETUP/ACCESS: `selx`, `enable`, `write`, `read` are all 0. `addr` and `w_data` hold their last values.
- Requester rules:
  - Hold `req_*` stable while `req_valid`=1 and no grant has been seen.
  - Deassert `req_valid` in the cycle after the grant unless another command is pending.
  - Commands from non-winners wait; they are never dropped.
- Simultaneous events:
  - The `rsp_valid` pulse and the next arbitration occur in the same IDLE cycle.
  - A requester may re-request in the IDLE cycle that carries its own response.
  - Round-robin gives it lowest priority there.
- Wait counter is `$clog2(TIMEOUT+1)` bits and saturates; no wrap.

## Timing
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs go to 0, including `addr` and `w_data`.
  - `last` = NUM_REQ-1, so requester 0 wins first.
  - A transfer in flight is dropped with no `rsp_valid`.
- Zero-wait command seen in IDLE at cycle 0:
  - cycle 1: SETUP and `req_grant`.
  - cycle 2: ACCESS.
  - cycle 3: IDLE and `rsp_valid`.
- Each wait state adds one cycle.
- Minimum spacing between transfers is 3 cycles; SETUP is always preceded by one IDLE cycle.
- Timeout case: `rsp_valid` with `rsp_err`=1 appears TIMEOUT+2 cycles after the grant cycle.

## Test plan
- **Single write, zero wait:** req0 write, addr=0x1000, wdata=0xA5.
  - `req_grant[0]` at cycle 1.
  - SETUP at cycle 1 with `write`=1, `read`=0.
  - `enable`=1 at cycle 2.
  - `rsp_valid[0]`=1, `rsp_err`=0, `rsp_rdata`=0 at cycle 3.
- **Read with 2 wait states:** req2 read, addr=0x20; `ready`=0,0,1; `r_data`=0x3C on the ready cycle.
  - `rsp_valid[2]` at cycle 5 with `rsp_rdata`=0x3C.
  - `addr` stable through all of ACCESS.
- **Full contention:** all four `req_valid` held from reset release, each requester re-requesting after its response.
  - Grant order 0,1,2,3,0,1…
  - Grants spaced exactly 3 cycles apart.
- **Fairness:** req1 and req3 pending with `last`=1.
  - req3 granted before req1.
  - req1 granted next.
- **Timeout:** TIMEOUT=4, `ready` stuck at 0.
  - `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 exactly 6 cycles after the grant cycle.
  - Bus returns to idle on the next cycle.
- **Reset mid-ACCESS:** assert `reset` between edges during ACCESS.
  - `selx`, `enable` and all outputs go to 0 immediately.
  - No `rsp_valid` pulse.
  - After release, requester 0 wins first.

Source files
------------

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ single-command requesters onto one
// APB bus and returns read data or a timeout error to the winner.
module apb_rr_master #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         w_data,
  input  logic [DATA_W-1:0]         r_data,
  output logic                      selx,
  output logic                      enable,
  output logic                      write,
  output logic                      read,
  input  logic                      ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W:0]   NREQ    = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                selx_q, selx_d;
  logic                enable_q, enable_d;
  logic                write_q, write_d;
  logic                read_q, read_d;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [IDX_W:0]      cand;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic                timeout_hit;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Search starts one past the previous winner and wraps, so the last winner
  // always ends up with the lowest priority.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W + 1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    req_grant_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    w_data_d    = w_data_q;
    selx_d      = selx_q;
    enable_d    = enable_q;
    write_d     = write_q;
    read_d      = read_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d              = SETUP;
          last_d               = win_idx;
          req_grant_d[win_idx] = 1'b1;
          addr_d               = addr_arr[win_idx];
          w_data_d             = wdata_arr[win_idx];
          write_d              = req_write[win_idx];
          read_d               = ~req_write[win_idx];
          selx_d               = 1'b1;
          enable_d             = 1'b0;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
        cnt_d    = '0;
      end
      ACCESS: begin
        // A ready slave wins over a timeout that expires in the same cycle.
        if (ready || timeout_hit) begin
          state_d             = IDLE;
          selx_d              = 1'b0;
          enable_d            = 1'b0;
          write_d             = 1'b0;
          read_d              = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = ~ready;
          rsp_rdata_d         = (ready && read_q) ? r_data : '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      req_grant_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      w_data_q    <= '0;
      selx_q      <= 1'b0;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      req_grant_q <= req_grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      w_data_q    <= w_data_d;
      selx_q      <= selx_d;
      enable_q    <= enable_d;
      write_q     <= write_d;
      read_q      <= read_d;
    end
  end

  assign req_grant = req_grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign w_data    = w_data_q;
  assign selx      = selx_q;
  assign enable    = enable_q;
  assign write     = write_q;
  assign read      = read_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: table of single transfers plus
// hand-written contention, fairness and reset sequences.
module tb_apb_rr_master;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 4;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_grant;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    w_data;
  logic [DW-1:0]    r_data;
  logic             selx;
  logic             enable;
  logic             write;
  logic             read;
  logic             ready;

  int checks   = 0;
  int failures = 0;

  apb_rr_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .w_data(w_data), .r_data(r_data),
    .selx(selx), .enable(enable), .write(write), .read(read), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned  req;
    logic         wr;
    logic [31:0]  a;
    logic [7:0]   wd;
    int unsigned  waits;     // ACCESS cycles with ready=0 before ready=1
    logic [7:0]   rd;        // r_data presented on the ready cycle
    int unsigned  exp_rsp;   // cycle of rsp_valid, request seen at cycle 0
    logic [7:0]   exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, input int maxc);
    g = '0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (req_grant != '0) begin
        g = req_grant;
        break;
      end
    end
  endtask

  logic [NR-1:0] exp_oh;
  logic [NR-1:0] g;
  int            grant_cyc [8];
  int            grant_idx [8];
  int            exp_ord   [8];
  int            ng;
  int            cyc;

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0000_1000, 8'hA5, 0,   8'h00, 3, 8'h00, 1'b0};
    vecs[1] = '{2, 1'b0, 32'h0000_0020, 8'h11, 2,   8'h3C, 5, 8'h3C, 1'b0};
    vecs[2] = '{1, 1'b0, 32'hDEAD_BEEF, 8'h22, 0,   8'h5A, 3, 8'h5A, 1'b0};
    vecs[3] = '{3, 1'b1, 32'h0000_0044, 8'h0F, 1,   8'h77, 4, 8'h00, 1'b0};
    vecs[4] = '{1, 1'b0, 32'h0000_0080, 8'h33, 255, 8'h99, 7, 8'h00, 1'b1};
    vecs[5] = '{2, 1'b0, 32'h0000_1234, 8'h44, 4,   8'hC3, 7, 8'hC3, 1'b0};
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};

    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    r_data    = '0;
    ready     = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_grant", 64'(req_grant), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_selx", 64'(selx), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Table of single transfers
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      set_req(int'(vecs[v].req), vecs[v].wr, vecs[v].a, vecs[v].wd);
      req_valid = '0;
      req_valid[vecs[v].req] = 1'b1;
      ready  = 1'b0;
      r_data = 8'hEE;
      exp_oh = '0;
      exp_oh[vecs[v].req] = 1'b1;
      for (int c = 1; c <= int'(vecs[v].exp_rsp); c++) begin
        @(posedge clk); #1;
        if (c == 2) req_valid = '0;
        ready  = (c >= 2 + int'(vecs[v].waits)) ? 1'b1 : 1'b0;
        r_data = (c == 2 + int'(vecs[v].waits)) ? vecs[v].rd : 8'hEE;
        @(negedge clk);
        chk("grant", 64'(req_grant), (c == 1) ? 64'(exp_oh) : 64'(0));
        chk("selx", 64'(selx), 64'(c < int'(vecs[v].exp_rsp)));
        chk("enable", 64'(enable), 64'((c >= 2) && (c < int'(vecs[v].exp_rsp))));
        if (c < int'(vecs[v].exp_rsp)) begin
          chk("addr", 64'(addr), 64'(vecs[v].a));
          chk("w_data", 64'(w_data), 64'(vecs[v].wd));
          chk("write", 64'(write), 64'(vecs[v].wr));
          chk("read", 64'(read), 64'(!vecs[v].wr));
        end else begin
          chk("write_idle", 64'(write), 64'(0));
          chk("read_idle", 64'(read), 64'(0));
        end
        chk("rsp_valid", 64'(rsp_valid), (c == int'(vecs[v].exp_rsp)) ? 64'(exp_oh) : 64'(0));
        if (c == int'(vecs[v].exp_rsp)) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(vecs[v].exp_rdata));
          chk("rsp_err", 64'(rsp_err), 64'(vecs[v].exp_err));
        end
      end
      $display("vector %0d: req%0d %s addr=%08h waits=%0d rdata=%02h err=%0b",
               v, vecs[v].req, vecs[v].wr ? "write" : "read", vecs[v].a,
               vecs[v].waits, rsp_rdata, rsp_err);
    end

    // Full contention from reset release
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, i[0], 32'h100 + 32'(i), 8'(8'h10 + i));
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '1;
    ready     = 1'b1;
    r_data    = 8'h00;
    ng  = 0;
    cyc = 0;
    while (ng < 8 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (req_grant != '0) begin
        grant_cyc[ng] = cyc;
        grant_idx[ng] = $clog2(int'(req_grant));
        exp_oh = '0;
        exp_oh[exp_ord[ng]] = 1'b1;
        chk("cont_grant", 64'(req_grant), 64'(exp_oh));
        if (ng == 0) chk("cont_first_cycle", 64'(cyc), 64'(1));
        else         chk("cont_spacing", 64'(cyc - grant_cyc[ng-1]), 64'(3));
        $display("contention grant %0d: req%0d at cycle %0d", ng, grant_idx[ng], cyc);
        ng++;
      end
    end
    chk("cont_grant_count", 64'(ng), 64'(8));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Fairness: make req1 the last winner, then raise req1 and req3 together
    #1;
    req_valid = 4'b0010;
    wait_grant(g, 10);
    chk("fair_setup_grant", 64'(g), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b1010;
    wait_grant(g, 10);
    chk("fair_first", 64'(g), 64'(4'b1000));
    $display("fairness first grant: %b", g);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_grant(g, 10);
    chk("fair_second", 64'(g), 64'(4'b0010));
    $display("fairness second grant: %b", g);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset in the middle of ACCESS
    #1;
    set_req(0, 1'b0, 32'h0000_55AA, 8'h66);
    ready     = 1'b0;
    req_valid = 4'b0001;
    wait_grant(g, 10);
    chk("mid_grant", 64'(g), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_enable_before", 64'(enable), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_selx", 64'(selx), 64'(0));
    chk("mid_enable", 64'(enable), 64'(0));
    chk("mid_read", 64'(read), 64'(0));
    chk("mid_addr", 64'(addr), 64'(0));
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    set_req(2, 1'b1, 32'h0000_0222, 8'h77);
    req_valid = 4'b0101;
    wait_grant(g, 10);
    chk("post_reset_winner", 64'(g), 64'(4'b0001));
    $display("post-reset first grant: %b", g);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
